// File: rtl/handshake_pkg.sv
// Shared sizing helpers for the handshake constant arbiter.
//   clog2(v) : ceiling log2 (clog2(1) = 0)
//   idx_w(n) : width of a requester index, never less than one bit
package handshake_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Cyclic priority search: grants the first asserted req bit at or after ptr,
// wrapping upward through index N-1 back to 0.
//   req       : request vector
//   ptr       : index with highest priority this cycle (must be < N)
//   grant     : one-hot grant, zero when no request
//   grant_idx : binary index of the granted bit
//   any       : at least one request asserted
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;
  logic          hi_any;

  // Lowest requester at/above ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    any    = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IW'(i);
        any    = 1'b1;
        if (i >= int'(ptr)) begin
          hi_idx = IW'(i);
          hi_any = 1'b1;
        end
      end
    end
    grant_idx = hi_any ? hi_idx : lo_idx;
    grant     = any ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/handshake_constant_arbiter.sv
// Round-robin arbiter over NUM_REQ token streams feeding a one-entry output
// register that always carries CONST_VALUE, tagged with the winner's index.
//   clk, rst      : clock, asynchronous active-low reset
//   ctrl_valid/ready : per-requester token handshake (ready is combinational)
//   outs, outs_index, outs_valid, outs_ready : output token handshake
//   issued_count  : tokens accepted since reset, wrapping
module handshake_constant_arbiter
  import handshake_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            NUM_REQ     = 4,
  parameter logic [DATA_WIDTH-1:0]  CONST_VALUE = DATA_WIDTH'(24'h082D01),
  parameter int unsigned            CNT_WIDTH   = 16,
  localparam int unsigned           IDX_W       = idx_w(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_W-1:0]      outs_index,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CNT_WIDTH-1:0]  issued_count
);

  logic                 full_q,   full_d;
  logic [IDX_W-1:0]     idx_q,    idx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;

  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_any;
  logic                 load_en;
  logic                 accept;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_arbiter (
    .req       (ctrl_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Stage can take a token when empty or draining this cycle; rst gates
  // ready so nothing is handshaken while reset is held.
  assign load_en    = !full_q || outs_ready;
  assign accept     = rst && grant_any && load_en;
  assign ctrl_ready = accept ? grant : '0;

  // Next-state for output stage, pointer and counter.
  always_comb begin
    full_d   = full_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (accept) begin
      full_d   = 1'b1;
      idx_d    = grant_idx;
      rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      cnt_d    = cnt_q + CNT_WIDTH'(1);
    end else if (outs_ready) begin
      full_d   = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q   <= 1'b0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      full_q   <= full_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign outs         = CONST_VALUE;
  assign outs_valid   = full_q;
  assign outs_index   = idx_q;
  assign issued_count = cnt_q;

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Bench for handshake_constant_arbiter (NUM_REQ=4, CNT_WIDTH=4): directed
// vectors with literal expectations plus a token-level reference model
// compared on every falling clock edge.
module tb_handshake_constant_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNTW  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   ctrl_valid = '0;
  logic [NREQ-1:0]   ctrl_ready;
  logic [31:0]       outs;
  logic [IDX_W-1:0]  outs_index;
  logic              outs_valid;
  logic              outs_ready = 1'b0;
  logic [CNTW-1:0]   issued_count;

  int checks = 0;
  int errors = 0;

  handshake_constant_arbiter #(
    .DATA_WIDTH (32),
    .NUM_REQ    (NREQ),
    .CNT_WIDTH  (CNTW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_valid   (ctrl_valid),
    .ctrl_ready   (ctrl_ready),
    .outs         (outs),
    .outs_index   (outs_index),
    .outs_valid   (outs_valid),
    .outs_ready   (outs_ready),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one held token, a priority pointer and a token tally.
  int m_full = 0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;

  function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < int'(NREQ); k++) begin
      int i = (ptr + k) % int'(NREQ);
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    int g = model_grant(ctrl_valid, m_ptr);
    if (rst && g >= 0 && (m_full == 0 || outs_ready)) return NREQ'(1) << g;
    return '0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_full <= 0; m_idx <= 0; m_ptr <= 0; m_cnt <= 0;
    end else begin
      int g;
      g = model_grant(ctrl_valid, m_ptr);
      if (g >= 0 && (m_full == 0 || outs_ready)) begin
        m_full <= 1;
        m_idx  <= g;
        m_ptr  <= (g + 1) % int'(NREQ);
        m_cnt  <= (m_cnt + 1) % (1 << CNTW);
      end else if (outs_ready) begin
        m_full <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_ctrl_ready",   32'(ctrl_ready),   32'(model_ready()));
    chk("m_outs_valid",   32'(outs_valid),   32'(m_full));
    chk("m_outs_index",   32'(outs_index),   32'(m_idx));
    chk("m_issued_count", 32'(issued_count), 32'(m_cnt));
    if (outs_valid) chk("m_outs", outs, 32'h00082D01);
  end

  task automatic drive(input logic [NREQ-1:0] v, input logic r);
    ctrl_valid = v;
    outs_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  logic [4:0] vec [12] = '{5'b1010_1, 5'b1010_0, 5'b0000_1, 5'b0110_1,
                           5'b1001_0, 5'b1001_1, 5'b1111_1, 5'b0000_0,
                           5'b0001_1, 5'b1000_1, 5'b0000_1, 5'b0101_1};

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_outs_valid", 32'(outs_valid), 0);
    chk("rst_issued", 32'(issued_count), 0);
    chk("rst_index", 32'(outs_index), 0);
    rst = 1'b1;

    // Single token, same-cycle accept, one-cycle latency
    drive(4'b0001, 1'b1);
    #1 chk("t1_ready", 32'(ctrl_ready), 32'h1);
    tick();
    chk("t1_valid", 32'(outs_valid), 1);
    chk("t1_outs", outs, 32'h00082D01);
    chk("t1_index", 32'(outs_index), 0);
    chk("t1_issued", 32'(issued_count), 1);
    drive(4'b0000, 1'b1);
    tick();
    chk("t1_drained", 32'(outs_valid), 0);

    // All requesting: round-robin order, one token per cycle
    pulse_reset();
    drive(4'b1111, 1'b1);
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_grant", 32'(ctrl_ready), 32'(1) << (k % 4));
      tick();
      chk("t2_index", 32'(outs_index), 32'(k % 4));
    end
    chk("t2_issued", 32'(issued_count), 8);

    // Backpressure, then accept in the same cycle as drain
    drive(4'b0100, 1'b0);
    #1 chk("t3_ready_blocked", 32'(ctrl_ready), 0);
    tick();
    chk("t3_index_stable", 32'(outs_index), 3);
    chk("t3_valid_held", 32'(outs_valid), 1);
    drive(4'b0100, 1'b1);
    #1 chk("t3_ready_drain", 32'(ctrl_ready), 32'h4);
    tick();
    chk("t3_index", 32'(outs_index), 2);
    chk("t3_valid", 32'(outs_valid), 1);
    chk("t3_issued", 32'(issued_count), 9);

    // Pointer at 3 wraps to requester 0, then advances to 1
    drive(4'b0011, 1'b1);
    #1 chk("t4_wrap", 32'(ctrl_ready), 32'h1);
    tick();
    chk("t4_index", 32'(outs_index), 0);
    #1 chk("t4_ptr1", 32'(ctrl_ready), 32'h2);
    tick();
    chk("t4_issued", 32'(issued_count), 11);

    // Mixed vectors, checked by the model only
    for (int k = 0; k < 12; k++) begin
      drive(vec[k][4:1], vec[k][0]);
      tick();
    end

    // Reset mid-stream with a token held
    drive(4'b1111, 1'b0);
    tick(); tick();
    chk("t5_pre_valid", 32'(outs_valid), 1);
    rst = 1'b0;
    #1;
    chk("t5_valid", 32'(outs_valid), 0);
    chk("t5_issued", 32'(issued_count), 0);
    chk("t5_ready", 32'(ctrl_ready), 0);
    tick();
    chk("t5_ready_hold", 32'(ctrl_ready), 0);
    rst = 1'b1;
    #1 chk("t5_resume", 32'(ctrl_ready), 32'h1);
    tick();
    chk("t5_resume_issued", 32'(issued_count), 1);

    // Counter wrap with 4-bit counter: 17 tokens -> 1
    pulse_reset();
    drive(4'b1111, 1'b1);
    repeat (17) tick();
    chk("t6_wrap", 32'(issued_count), 1);
    chk("t6_index", 32'(outs_index), 0);

    drive(4'b0000, 1'b1);
    tick(); tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
